burst_target: RTL and testbench

BURST_TARGET -- requirements
Module: burst_target

---
 rtl/target_pkg.sv | 6 +
 rtl/target_mem.sv | 28 ++
 rtl/burst_target.sv | 130 +++++++++++++
 tb/tb_burst_target.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/target_pkg.sv
// target_pkg: shared types and widths for burst_target.
package target_pkg;
    localparam int LEN_W      = 4;
    localparam int ADDR_BUS_W = 16;
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD_WAIT, S_READ, S_ERR} state_t;
endpackage

// File: rtl/target_mem.sv
// target_mem: word storage with one synchronous write port and one registered read port.
module target_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    // only the output register is cleared; it holds between reads
    always_ff @(posedge clk or posedge rst)
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];

    assign o_rdata = r_rdata;
endmodule

// File: rtl/burst_target.sv
// burst_target: burst read/write memory target with optional read wait states.
// Define BURST_TARGET_ERR_EN to flag out-of-window start addresses with target_err.
module burst_target
    import target_pkg::*;
#(
    parameter int                    DATA_W    = 8,
    parameter int                    MEM_DEPTH = 256,
    parameter logic [ADDR_BUS_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                    RD_WAIT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BUS_W-1:0] target_addr_in,
    input  logic                  target_addr_in_valid,
    input  logic                  target_rw,
    input  logic [LEN_W-1:0]      target_burst_len,
    input  logic [DATA_W-1:0]     target_data_in,
    input  logic                  target_data_in_valid,
    output logic [DATA_W-1:0]     target_data_out,
    output logic                  target_data_out_valid,
    output logic                  target_ack,
    output logic                  target_err,
    output logic                  target_ready
);
    localparam int                ADDR_W    = (MEM_DEPTH <= 2) ? 1 : $clog2(MEM_DEPTH);
    localparam logic [LEN_W-1:0]  WAIT_INIT = LEN_W'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MEM_DEPTH - 1);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_idx, w_idx, w_idx_inc, w_start;
    logic [LEN_W:0]    r_cnt, w_cnt;
    logic [LEN_W-1:0]  r_wait;
    logic              r_dv, r_ack;
    logic              w_acc, w_oor, w_we, w_re, w_beat, w_last;

    assign w_start = ADDR_W'(target_addr_in - BASE_ADDR);
`ifdef BURST_TARGET_ERR_EN
    logic r_err;
    assign w_oor = (target_addr_in < BASE_ADDR) ||
                   (({16'h0, target_addr_in} - {16'h0, BASE_ADDR}) >= 32'(MEM_DEPTH));
    always_ff @(posedge clk or posedge rst)
        if (rst) r_err <= 1'b0;
        else r_err <= w_acc && w_oor;
    assign target_err = r_err;
`else
    assign w_oor      = 1'b0;
    assign target_err = 1'b0;
`endif

    // in IDLE the beat index/count come straight from the command so beat 0 can start at once
    assign w_acc     = target_addr_in_valid && (r_state == S_IDLE);
    assign w_idx     = (r_state == S_IDLE) ? w_start : r_idx;
    assign w_cnt     = (r_state == S_IDLE) ? {1'b0, target_burst_len} + 1'b1 : r_cnt;
    assign w_last    = w_cnt == (LEN_W + 1)'(1);
    assign w_beat    = w_we || w_re;
    assign w_idx_inc = (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        w_re   = 1'b0;
        case (r_state)
            S_IDLE:
                if (w_acc) begin
                    if (w_oor) w_next = S_ERR;
                    else if (target_rw) begin
                        w_we   = target_data_in_valid;
                        w_next = (w_we && w_last) ? S_IDLE : S_WRITE;
                    end else if (RD_WAIT == 0) begin
                        w_re   = 1'b1;
                        w_next = w_last ? S_IDLE : S_READ;
                    end else w_next = S_RD_WAIT;
                end
            S_WRITE: begin
                w_we   = target_data_in_valid;
                w_next = (w_we && w_last) ? S_IDLE : S_WRITE;
            end
            S_RD_WAIT:
                if (r_wait == '0) begin
                    w_re   = 1'b1;
                    w_next = w_last ? S_IDLE : S_READ;
                end
            S_READ: begin
                w_re   = 1'b1;
                w_next = w_last ? S_IDLE : S_READ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_wait <= '0;
            r_dv   <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_dv  <= w_re;
            r_ack <= (w_beat && w_last) || (w_acc && w_oor);
            if (w_beat) begin
                r_idx <= w_idx_inc;
                r_cnt <= w_cnt - 1'b1;
            end else if (w_acc) begin
                r_idx <= w_start;
                r_cnt <= w_cnt;
            end
            r_wait <= w_acc ? WAIT_INIT :
                      (r_state == S_RD_WAIT && r_wait != '0) ? r_wait - 1'b1 : r_wait;
        end

    target_mem #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (target_data_in),
        .i_re    (w_re),
        .i_raddr (w_idx),
        .o_rdata (target_data_out)
    );

    assign target_data_out_valid = r_dv;
    assign target_ack            = r_ack;
    assign target_ready          = r_state == S_IDLE;
endmodule

// File: tb/tb_burst_target.sv
// tb_burst_target: table-driven burst write/read checks with a read-data scoreboard.
module tb_burst_target;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a0 = '0, a1 = '0, a2 = '0;
    logic av0 = 0, av1 = 0, av2 = 0, rw0 = 0, rw1 = 0, rw2 = 0, dinv0 = 0, dinv1 = 0, dinv2 = 0;
    logic [3:0] len0 = '0, len1 = '0, len2 = '0;
    logic [7:0] din0 = '0, din1 = '0, din2 = '0, d0, d1, d2;
    logic dv0, dv1, dv2, ack0, ack1, ack2, err0, err1, err2, rdy0, rdy1, rdy2;

    int n_chk = 0, n_pass = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mem_m [256];

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  len;
        logic [7:0]  seed;
        logic [7:0]  exp_last;
    } vec_t;
    vec_t tbl [5];

    burst_target u_dut0 (
        .clk(clk), .rst(rst), .target_addr_in(a0), .target_addr_in_valid(av0), .target_rw(rw0),
        .target_burst_len(len0), .target_data_in(din0), .target_data_in_valid(dinv0),
        .target_data_out(d0), .target_data_out_valid(dv0), .target_ack(ack0),
        .target_err(err0), .target_ready(rdy0));

    burst_target #(.RD_WAIT(3)) u_dut1 (
        .clk(clk), .rst(rst), .target_addr_in(a1), .target_addr_in_valid(av1), .target_rw(rw1),
        .target_burst_len(len1), .target_data_in(din1), .target_data_in_valid(dinv1),
        .target_data_out(d1), .target_data_out_valid(dv1), .target_ack(ack1),
        .target_err(err1), .target_ready(rdy1));

    burst_target #(.BASE_ADDR(16'h1000)) u_dut2 (
        .clk(clk), .rst(rst), .target_addr_in(a2), .target_addr_in_valid(av2), .target_rw(rw2),
        .target_burst_len(len2), .target_data_in(din2), .target_data_in_valid(dinv2),
        .target_data_out(d2), .target_data_out_valid(dv2), .target_ack(ack2),
        .target_err(err2), .target_ready(rdy2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (dv0) begin
            logic [7:0] e;
            chk("rd_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(d0), 32'(e));
            end
        end

    task automatic do_write(input logic [15:0] addr, input logic [3:0] len, input logic [7:0] seed,
                            input int gap_at, input int gap);
        a0 = addr; av0 = 1; rw0 = 1; len0 = len; din0 = seed; dinv0 = 1;
        mem_m[addr[7:0]] = seed;
        cyc();
        av0 = 0; dinv0 = 0;
        for (int k = 1; k <= int'(len); k++) begin
            if (k == gap_at) repeat (gap) begin
                chk("wr_stall_noack", 32'(ack0), 0);
                cyc();
            end
            chk("wr_mid_noack", 32'(ack0), 0);
            din0 = seed + 8'(k); dinv0 = 1;
            mem_m[8'(int'(addr) + k)] = din0;
            cyc();
            dinv0 = 0;
        end
        chk("wr_ack", 32'(ack0), 1);
        chk("wr_ready", 32'(rdy0), 1);
        cyc();
        chk("wr_ack_pulse", 32'(ack0), 0);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [3:0] len, input bit noise);
        for (int k = 0; k <= int'(len); k++) exp_q.push_back(mem_m[8'(int'(addr) + k)]);
        a0 = addr; av0 = 1; rw0 = 0; len0 = len;
        cyc();
        av0 = 0;
        for (int k = 0; k <= int'(len); k++) begin
            if (noise && k < int'(len)) begin
                a0 = 16'h0010; av0 = 1; rw0 = 1; len0 = 0; din0 = 8'hEE; dinv0 = 1;
            end else begin
                av0 = 0; dinv0 = 0;
            end
            chk("rd_valid", 32'(dv0), 1);
            chk("rd_ack", 32'(ack0), 32'(k == int'(len)));
            chk("rd_busy", 32'(rdy0), 32'(k == int'(len)));
            cyc();
        end
        av0 = 0; dinv0 = 0;
        chk("rd_done_valid", 32'(dv0), 0);
        chk("rd_done_ack", 32'(ack0), 0);
    endtask

    initial begin
        tbl[0] = '{16'h00FE, 4'd3,  8'h01, 8'h04};
        tbl[1] = '{16'h0020, 4'd0,  8'h90, 8'h90};
        tbl[2] = '{16'h0030, 4'd15, 8'h40, 8'h4F};
        tbl[3] = '{16'h00F8, 4'd9,  8'hC0, 8'hC9};
        tbl[4] = '{16'h0080, 4'd7,  8'h10, 8'h17};

        repeat (2) cyc();
        chk("rst_valid", 32'(dv0), 0);
        chk("rst_ack", 32'(ack0), 0);
        chk("rst_data", 32'(d0), 0);
        chk("rst_err", 32'(err0), 0);
        rst = 0;
        chk("rst_ready", 32'(rdy0), 1);

        do_write(16'h0010, 4'd0, 8'h5A, 0, 0);
        do_read(16'h0010, 4'd0, 0);

        for (int i = 0; i < 5; i++) begin
            do_write(tbl[i].addr, tbl[i].len, tbl[i].seed, 0, 0);
            do_read(tbl[i].addr, tbl[i].len, i == 2);
            chk("rd_hold", 32'(d0), 32'(tbl[i].exp_last));
        end

        do_read(16'h0010, 4'd0, 0);
        do_read(16'h0030, 4'd14, 0);
        din0 = 8'hEE; dinv0 = 1;
        cyc();
        dinv0 = 0;
        do_read(16'h003F, 4'd0, 0);

        do_write(16'h0040, 4'd2, 8'h30, 2, 2);
        do_read(16'h0040, 4'd2, 0);

        exp_q.push_back(mem_m[8'h80]);
        exp_q.push_back(mem_m[8'h81]);
        a0 = 16'h0080; av0 = 1; rw0 = 0; len0 = 4'd7;
        cyc();
        av0 = 0;
        cyc();
        @(negedge clk);
        #1;
        rst = 1;
        #1;
        chk("midrst_valid", 32'(dv0), 0);
        chk("midrst_ack", 32'(ack0), 0);
        chk("midrst_data", 32'(d0), 0);
        repeat (2) cyc();
        rst = 0;
        chk("midrst_ready", 32'(rdy0), 1);
        do_read(16'h0080, 4'd7, 0);

        a1 = 16'h0003; av1 = 1; rw1 = 1; len1 = 0; din1 = 8'hA5; dinv1 = 1;
        cyc();
        av1 = 0; dinv1 = 0;
        chk("w1_ack", 32'(ack1), 1);
        cyc();
        av1 = 1; rw1 = 0;
        cyc();
        av1 = 0;
        for (int i = 1; i <= 3; i++) begin
            chk("wait_novalid", 32'(dv1), 0);
            chk("wait_busy", 32'(rdy1), 0);
            cyc();
        end
        chk("wait_valid", 32'(dv1), 1);
        chk("wait_data", 32'(d1), 32'h A5);
        chk("wait_ack", 32'(ack1), 1);
        cyc();
        chk("wait_done", 32'(dv1), 0);

        a2 = 16'h1005; av2 = 1; rw2 = 1; len2 = 0; din2 = 8'h77; dinv2 = 1;
        cyc();
        av2 = 0; dinv2 = 0;
        chk("base_wr_ack", 32'(ack2), 1);
        chk("base_wr_err", 32'(err2), 0);
        cyc();
        a2 = 16'h0005; av2 = 1; rw2 = 0;
        cyc();
        av2 = 0;
`ifdef BURST_TARGET_ERR_EN
        chk("err_ack", 32'(ack2), 1);
        chk("err_err", 32'(err2), 1);
        chk("err_novalid", 32'(dv2), 0);
        cyc();
        chk("err_ack_pulse", 32'(ack2), 0);
        chk("err_err_pulse", 32'(err2), 0);
        chk("err_novalid2", 32'(dv2), 0);
        cyc();
        chk("err_ready", 32'(rdy2), 1);
`else
        chk("trunc_valid", 32'(dv2), 1);
        chk("trunc_data", 32'(d2), 32'h77);
        chk("trunc_ack", 32'(ack2), 1);
        chk("trunc_err", 32'(err2), 0);
`endif
        cyc();
        chk("q_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
